ahfp_sub_multi: RTL and testbench
=================================

AHFP_SUB_MULTI -- requirements
Module: ahfp_sub_multi

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port clk_en, input, 1 bit: when 0, all registers, the FSM state and done hold their values.
REQ-004 SHALL have port start, input, 1 bit: request; sampled only in IDLE with clk_en=1.
REQ-005 SHALL have port dataa, input, 32 bits: IEEE-754 single minuend; captured on the accepting edge.
REQ-006 SHALL have port datab, input, 32 bits: IEEE-754 single subtrahend; captured on the accepting edge.
REQ-007 SHALL have port result, output, 32 bits: dataa - datab, registered; holds until the next completion.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse with result valid.

Function
REQ-009 SHALL implement FSM states IDLE, UNPACK, ALIGN, ADDSUB, NORM, ROUND, DONE, with all transitions gated by clk_en.
REQ-010 SHALL, in IDLE with start=1, capture both operands, invert the datab sign and go to UNPACK; start in any other state SHALL be ignored.
REQ-011 SHALL, in UNPACK, flush exp=0 operands to signed zero (no denormal support), form 24-bit significands with hidden 1 plus 3 low bits G/R/S (27 bits), and swap so operand A has the larger magnitude.
REQ-012 SHALL, in UNPACK, go directly to DONE when either exponent is 255 (specials): one inf gives that inf (datab sign inverted); inf - inf of the same sign gives 0x7FC00000; any NaN input gives 0x7FC00000.
REQ-013 SHALL, in ALIGN, right-shift B by expA-expB, saturating the shift at 27, with all shifted-out bits ORed into S.
REQ-014 SHALL, in ADDSUB, add when the effective signs match and subtract B from A otherwise, into a 28-bit sum; result sign = sign of A.
REQ-015 SHALL, in NORM, right-shift once with exp+1 on carry (bit 27), otherwise left-shift one bit per cycle with exp-1 until bit 26 = 1.
REQ-016 SHALL, in NORM, output +0 (0x00000000) and go to ROUND with no shifts if the sum is zero.
REQ-017 SHALL, in NORM, stop shifting and flush to +0 if the exponent reaches 0.
REQ-018 SHALL, in ROUND, round to nearest-even on G/R/S; a mantissa carry-out SHALL renormalise with exp+1.
REQ-019 SHALL, in ROUND, give sign|0x7F800000 when exp >= 255.
REQ-020 SHALL, in DONE, register result, assert done for exactly one cycle and return to IDLE.
REQ-021 SHALL make a new start acceptable on the first edge after done falls.
REQ-022 SHALL set normal-path latency to done high 5+k enabled edges after the accepting edge, where k = number of NORM shift cycles (0..25).
REQ-023 SHALL set special-path latency to done high 2 enabled edges after the accepting edge.
REQ-024 SHALL stretch the latency by one cycle per clk_en=0 cycle, with no other effect.

Reset
REQ-025 SHALL, while reset_n=0, force state=IDLE, done=0, result=0x00000000 and all internal registers to 0, regardless of clk.
REQ-026 SHALL abort any operation in progress when reset_n is asserted mid-operation, producing no done pulse.
REQ-027 SHALL, after release, accept start on the first rising edge.

Verification
REQ-028 SHALL cover 0x40400000 - 0x3F800000 -> 0x40000000, done at edge 5 (k=0).
REQ-029 SHALL cover 0x3F800000 - 0xBF800000 -> 0x40000000 (effective add, carry path).
REQ-030 SHALL cover 0x3F800000 - 0x3F7FFFFF -> 0x33800000, done at edge 29 (k=24).
REQ-031 SHALL cover 0x3F800000 - 0x3F800000 -> 0x00000000, done at edge 5.
REQ-032 SHALL cover 0x7F800000 - 0x7F800000 -> 0x7FC00000, done at edge 2.
REQ-033 SHALL cover 0x7F7FFFFF - 0xFF7FFFFF -> 0x7F800000 (overflow).
REQ-034 SHALL cover reset_n low in NORM -> no done pulse, result=0; next start computes correctly.
REQ-035 SHALL cover start held high through an operation -> only one operation per done, with each new capture on the edge after done.

Source files
------------

// File: rtl/ahfp_sub_multi.sv
// ahfp_sub_multi: multi-cycle IEEE-754 single-precision subtractor (dataa - datab).
// Sequenced as IDLE -> UNPACK -> ALIGN -> ADDSUB -> NORM (1+k cycles) -> ROUND -> DONE.
// Denormal inputs are flushed to signed zero and denormal results are flushed to +0.
// Special operands (exp = 255) bypass the datapath: UNPACK hands the special result
// to DONE, which then publishes it one cycle later.
module ahfp_sub_multi (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clk_en,
   input  logic        start,
   input  logic [31:0] dataa,
   input  logic [31:0] datab,
   output logic [31:0] result,
   output logic        done
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      UNPACK = 3'd1,
      ALIGN  = 3'd2,
      ADDSUB = 3'd3,
      NORM   = 3'd4,
      ROUND  = 3'd5,
      DONE   = 3'd6
   } state_t;

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   state_t      state_q, state_d;
   logic [31:0] op_a_q, op_a_d;       // captured minuend
   logic [31:0] op_b_q, op_b_d;       // captured subtrahend, sign already inverted
   logic        sign_a_q, sign_a_d;   // larger-magnitude operand
   logic        sign_b_q, sign_b_d;
   logic [7:0]  exp_a_q, exp_a_d;
   logic [7:0]  exp_b_q, exp_b_d;
   logic [26:0] man_a_q, man_a_d;     // {hidden, frac[22:0], G, R, S}
   logic [26:0] man_b_q, man_b_d;
   logic [27:0] sum_q, sum_d;         // bit 27 is the carry out of the add
   logic [8:0]  exp_q, exp_d;         // 9 bits so overflow past 255 is visible
   logic        sign_q, sign_d;
   logic        zero_q, zero_d;       // result forced to +0
   logic        pend_q, pend_d;       // special result waiting in res_q
   logic [31:0] res_q, res_d;
   logic [31:0] result_q, result_d;
   logic        done_q, done_d;

   // UNPACK helpers
   logic [7:0]  ea, eb;
   logic [22:0] fa, fb;
   logic [26:0] ma, mb;
   logic        nan_a, nan_b, inf_a, inf_b, swap;
   // ALIGN helpers
   logic [7:0]  diff;
   logic [4:0]  sh;
   logic [26:0] mask;
   // ROUND helpers
   logic [23:0] mant24;
   logic        round_up;
   logic [24:0] m25;
   logic [8:0]  exp_r;
   logic [22:0] frac_r;

   assign result = result_q;
   assign done   = done_q;

   // Next-state and datapath: every register holds unless its state updates it.
   always_comb begin
      state_d  = state_q;
      op_a_d   = op_a_q;
      op_b_d   = op_b_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      exp_a_d  = exp_a_q;
      exp_b_d  = exp_b_q;
      man_a_d  = man_a_q;
      man_b_d  = man_b_q;
      sum_d    = sum_q;
      exp_d    = exp_q;
      sign_d   = sign_q;
      zero_d   = zero_q;
      pend_d   = pend_q;
      res_d    = res_q;
      result_d = result_q;
      done_d   = 1'b0;

      ea    = op_a_q[30:23];
      eb    = op_b_q[30:23];
      fa    = op_a_q[22:0];
      fb    = op_b_q[22:0];
      ma    = (ea == 8'd0) ? 27'd0 : {1'b1, fa, 3'b000};
      mb    = (eb == 8'd0) ? 27'd0 : {1'b1, fb, 3'b000};
      nan_a = (ea == 8'hFF) && (fa != 23'd0);
      nan_b = (eb == 8'hFF) && (fb != 23'd0);
      inf_a = (ea == 8'hFF) && (fa == 23'd0);
      inf_b = (eb == 8'hFF) && (fb == 23'd0);
      swap  = {eb, mb} > {ea, ma};

      diff  = exp_a_q - exp_b_q;
      sh    = (diff > 8'd27) ? 5'd27 : diff[4:0];
      // At sh = 27 the shift wraps to zero, so the mask becomes all ones.
      mask  = (27'd1 << sh) - 27'd1;

      mant24   = sum_q[26:3];
      round_up = sum_q[2] & (sum_q[1] | sum_q[0] | mant24[0]);
      m25      = {1'b0, mant24} + {24'd0, round_up};
      exp_r    = exp_q + {8'd0, m25[24]};
      frac_r   = m25[24] ? m25[23:1] : m25[22:0];

      case (state_q)
         IDLE: begin
            if (start) begin
               op_a_d  = dataa;
               op_b_d  = {~datab[31], datab[30:0]};
               state_d = UNPACK;
            end
         end
         UNPACK: begin
            zero_d = 1'b0;
            if ((ea == 8'hFF) || (eb == 8'hFF)) begin
               if (nan_a || nan_b)
                  res_d = QNAN;
               else if (inf_a && inf_b)
                  res_d = (op_a_q[31] == op_b_q[31]) ? op_a_q : QNAN;
               else if (inf_a)
                  res_d = op_a_q;
               else
                  res_d = op_b_q;
               pend_d  = 1'b1;
               state_d = DONE;
            end else begin
               sign_a_d = swap ? op_b_q[31] : op_a_q[31];
               sign_b_d = swap ? op_a_q[31] : op_b_q[31];
               exp_a_d  = swap ? eb : ea;
               exp_b_d  = swap ? ea : eb;
               man_a_d  = swap ? mb : ma;
               man_b_d  = swap ? ma : mb;
               state_d  = ALIGN;
            end
         end
         ALIGN: begin
            man_b_d = (man_b_q >> sh) | {26'd0, |(man_b_q & mask)};
            state_d = ADDSUB;
         end
         ADDSUB: begin
            if (sign_a_q == sign_b_q)
               sum_d = {1'b0, man_a_q} + {1'b0, man_b_q};
            else
               sum_d = {1'b0, man_a_q} - {1'b0, man_b_q};
            sign_d  = sign_a_q;
            exp_d   = {1'b0, exp_a_q};
            state_d = NORM;
         end
         NORM: begin
            if (sum_q == 28'd0) begin
               zero_d  = 1'b1;
               state_d = ROUND;
            end else if (sum_q[27]) begin
               // Carry: shift right once, folding the dropped bit into sticky.
               sum_d   = {1'b0, sum_q[27:2], sum_q[1] | sum_q[0]};
               exp_d   = exp_q + 9'd1;
               state_d = ROUND;
            end else if (sum_q[26]) begin
               state_d = ROUND;
            end else if (exp_q <= 9'd1) begin
               // Another shift would need exponent 0: flush the denormal to +0.
               zero_d  = 1'b1;
               state_d = ROUND;
            end else begin
               // Multi-bit cancellation only occurs with exponents within one of
               // each other, so the sticky bit is still exact when shifted left.
               sum_d = {sum_q[26:0], 1'b0};
               exp_d = exp_q - 9'd1;
            end
         end
         ROUND: begin
            if (zero_q)
               result_d = 32'd0;
            else if (exp_r >= 9'd255)
               result_d = {sign_q, 8'hFF, 23'd0};
            else
               result_d = {sign_q, exp_r[7:0], frac_r};
            done_d  = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            if (pend_q) begin
               // Special path: publish the staged result, stay one more cycle.
               result_d = res_q;
               done_d   = 1'b1;
               pend_d   = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register: asynchronous clear, updates only on enabled edges.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         op_a_q   <= '0;
         op_b_q   <= '0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         exp_a_q  <= '0;
         exp_b_q  <= '0;
         man_a_q  <= '0;
         man_b_q  <= '0;
         sum_q    <= '0;
         exp_q    <= '0;
         sign_q   <= 1'b0;
         zero_q   <= 1'b0;
         pend_q   <= 1'b0;
         res_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else if (clk_en) begin
         state_q  <= state_d;
         op_a_q   <= op_a_d;
         op_b_q   <= op_b_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         exp_a_q  <= exp_a_d;
         exp_b_q  <= exp_b_d;
         man_a_q  <= man_a_d;
         man_b_q  <= man_b_d;
         sum_q    <= sum_d;
         exp_q    <= exp_d;
         sign_q   <= sign_d;
         zero_q   <= zero_d;
         pend_q   <= pend_d;
         res_q    <= res_d;
         result_q <= result_d;
         done_q   <= done_d;
      end
   end

endmodule

// File: tb/tb_ahfp_sub_multi.sv
// Scoreboard bench for ahfp_sub_multi: stimulus pushes expected result, latency and
// accepting edge; a monitor pops and checks on every done pulse.
module tb_ahfp_sub_multi;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        clk_en = 1'b1;
   logic        start = 1'b0;
   logic [31:0] dataa = '0;
   logic [31:0] datab = '0;
   logic [31:0] result;
   logic        done;

   int cyc = 0;
   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] res;
      int          lat;   // edges from accept to done; -1 = not checked
      int          acc;   // accepting edge number
      string       name;
   } exp_t;
   exp_t sb_q[$];

   ahfp_sub_multi dut (
      .clk     (clk),
      .reset_n (reset_n),
      .clk_en  (clk_en),
      .start   (start),
      .dataa   (dataa),
      .datab   (datab),
      .result  (result),
      .done    (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end else
         $display("ok   %s: %h", name, act);
   endtask

   task automatic chk_int(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: result=%h with nothing outstanding", result);
            end else begin
               e = sb_q.pop_front();
               chk32({e.name, "_result"}, result, e.res);
               if (e.lat >= 0)
                  chk_int({e.name, "_latency"}, cyc - e.acc, e.lat);
            end
         end
      end
   end

   // Issue one request; returns once it has been accepted.
   task automatic issue(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input int lat, input string name);
      @(negedge clk);
      dataa = a;
      datab = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      sb_q.push_back('{r, lat, cyc, name});
      start = 1'b0;
   endtask

   // Wait (bounded) for all outstanding expectations to be consumed.
   task automatic drain(input string name);
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: %0d results still outstanding after 200 cycles", name, sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic run(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] r, input int lat, input string name);
      issue(a, b, r, lat, name);
      drain(name);
   endtask

   initial begin
      int a0;

      // Reset state
      repeat (3) @(negedge clk);
      chk32("reset_result", result, 32'h0000_0000);
      chk32("reset_done", {31'd0, done}, 32'd0);
      reset_n = 1'b1;

      // Directed vectors: a, b, a-b, latency
      run(32'h4040_0000, 32'h3F80_0000, 32'h4000_0000,  5, "3_minus_1");
      run(32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000,  5, "1_minus_neg1_carry");
      run(32'h3F80_0000, 32'h3F7F_FFFF, 32'h3380_0000, 29, "cancel_k24");
      run(32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000,  5, "1_minus_1_zero");
      run(32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000,  2, "inf_minus_inf");
      run(32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000,  5, "overflow");
      run(32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000,  2, "nan_in");
      run(32'h3F80_0000, 32'h7F80_0000, 32'hFF80_0000,  2, "1_minus_inf");
      run(32'h7F80_0000, 32'hFF80_0000, 32'h7F80_0000,  2, "inf_minus_neginf");
      run(32'h4000_0000, 32'h4040_0000, 32'hBF80_0000,  6, "2_minus_3_k1");
      run(32'h3F80_0000, 32'h3300_0000, 32'h3F80_0000,  6, "tie_round_up_even");
      run(32'h3F80_0000, 32'hB380_0000, 32'h3F80_0000,  5, "tie_round_down_even");
      run(32'h0000_0001, 32'h3F80_0000, 32'hBF80_0000,  5, "denorm_flush");
      run(32'h0000_0000, 32'h0000_0000, 32'h0000_0000,  5, "zero_minus_zero");
      run(32'h0080_0001, 32'h0080_0000, 32'h0000_0000, -1, "underflow_flush");

      // clk_en low for 3 edges stretches latency from 5 to 8
      @(negedge clk);
      dataa = 32'h4040_0000;
      datab = 32'h3F80_0000;
      start = 1'b1;
      @(posedge clk);
      #1;
      sb_q.push_back('{32'h4000_0000, 8, cyc, "clk_en_stall"});
      start = 1'b0;
      @(negedge clk);
      clk_en = 1'b0;
      repeat (3) @(negedge clk);
      clk_en = 1'b1;
      drain("clk_en_stall");

      // Start held high: captures every 7 edges (done at +5, falls at +6, accept +7)
      @(negedge clk);
      dataa = 32'h4040_0000;
      datab = 32'h3F80_0000;
      start = 1'b1;
      @(posedge clk);
      #1;
      a0 = cyc;
      sb_q.push_back('{32'h4000_0000, 5, a0,      "held_op0"});
      sb_q.push_back('{32'h4000_0000, 5, a0 + 7,  "held_op1"});
      sb_q.push_back('{32'h4000_0000, 5, a0 + 14, "held_op2"});
      repeat (14) @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      drain("held");

      // Reset asserted while in NORM: operation aborted, no done pulse
      @(negedge clk);
      dataa = 32'h3F80_0000;
      datab = 32'h3F7F_FFFF;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (6) @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk32("midop_reset_result", result, 32'h0000_0000);
      chk32("midop_reset_done", {31'd0, done}, 32'd0);
      repeat (3) @(negedge clk);
      // Release and request on the very first edge after release
      reset_n = 1'b1;
      dataa = 32'h4040_0000;
      datab = 32'h3F80_0000;
      start = 1'b1;
      @(posedge clk);
      #1;
      sb_q.push_back('{32'h4000_0000, 5, cyc, "after_reset"});
      start = 1'b0;
      drain("after_reset");
      repeat (40) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
